// File: rtl/wb_host_bridge.sv
// Wishbone classic single-transfer initiator: valid/ready command in, one bus cycle out, response back.
// Optional WB_HOST_BRIDGE_ERR_EN adds wbm_err_i; otherwise only the bus timeout sets rsp_err.
module wb_host_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
`ifdef WB_HOST_BRIDGE_ERR_EN
  input  logic        wbm_err_i,
`endif
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMO_W-1:0] cnt;
  logic             bus_err;
  logic             tmo_hit;

`ifdef WB_HOST_BRIDGE_ERR_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  // TIMEOUT_CYCLES == 0 means the bus phase may last forever.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'h0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            cnt       <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // Priority: err, then ack, then timeout; ack on the timeout edge succeeds.
          if (bus_err || wbm_ack_i || tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
            if (!bus_err && wbm_ack_i) begin
              rsp_err <= 1'b0;
              rsp_dat <= wbm_we_o ? 32'h0 : wbm_dat_i;
            end else begin
              rsp_err <= 1'b1;
              rsp_dat <= 32'h0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
